// File: rtl/dsss_mod.sv
// dsss_mod -- direct-sequence spread-spectrum BPSK modulator.
//
// One data bit per symbol is spread by a 31-chip m-sequence (x^5+x^2+1)
// and the resulting chip stream BPSK-modulates a DDS sine carrier.
//
// Parameters:
//   CHIP_DIV   clocks per chip (>= 2)
//   FREQ_WORD  32-bit carrier phase increment per clock
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   din        data bit to transmit
//   din_valid  din is presented
//   din_ready  one-entry buffer can take din this cycle
//   dout       signed 8-bit IF sample (-127..127)
//   bit_sync   one-cycle pulse on the first dout sample of each bit
//   pn         current chip (data XOR PN), aligned with dout
//   underrun   sticky: a bit boundary passed with the buffer empty
module dsss_mod #(
    parameter int unsigned CHIP_DIV  = 16,
    parameter logic [31:0] FREQ_WORD = 32'd692736661
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic signed [7:0] dout,
    output logic              bit_sync,
    output logic              pn,
    output logic              underrun
);

    localparam int unsigned   CW        = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam logic [CW-1:0] CHIP_LAST = CW'(CHIP_DIV - 1);
    localparam logic [4:0]    IDX_LAST  = 5'd30;

    logic [31:0]   phase_acc;
    logic [CW-1:0] chip_cnt;
    logic [4:0]    chip_idx;
    logic [4:0]    lfsr;
    logic          cur_bit;
    logic          buf_full;
    logic          buf_bit;

    logic          chip_tick;
    logic          bit_edge;
    logic          accept;

    // Stage 1: carrier table index, chip value and bit-start flag
    logic [7:0]    s1_k;
    logic          s1_s;
    logic          s1_b;

    logic [6:0]    q_idx;
    logic [6:0]    mag;
    logic          neg;
    logic signed [7:0] mag_s;

    assign din_ready = ~buf_full & ~rst;
    assign accept    = din_valid & din_ready;
    assign chip_tick = (chip_cnt == CHIP_LAST);
    assign bit_edge  = chip_tick && (chip_idx == IDX_LAST);

    // Quarter-wave table: round(127*sin(2*pi*k/256)) for k = 0..64
    function automatic logic [6:0] quarter_sine(input logic [6:0] k);
        logic [6:0] q;
        q = '0;
        case (k)
            7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
            7'd4:  q = 7'd12;  7'd5:  q = 7'd16;  7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
            7'd8:  q = 7'd25;  7'd9:  q = 7'd28;  7'd10: q = 7'd31;  7'd11: q = 7'd34;
            7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
            7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
            7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
            7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
            7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
            7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
            7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
            7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
            7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
            7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
            7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
            7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
            7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
            7'd64: q = 7'd127;
            default: q = '0;
        endcase
        return q;
    endfunction

    // Chip timing, spreading code and the one-entry input buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_acc <= '0;
            chip_cnt  <= '0;
            chip_idx  <= '0;
            lfsr      <= '1;
            cur_bit   <= 1'b0;
            buf_full  <= 1'b0;
            buf_bit   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            phase_acc <= phase_acc + FREQ_WORD;
            chip_cnt  <= chip_tick ? '0 : chip_cnt + CW'(1);

            if (chip_tick) begin
                chip_idx <= (chip_idx == IDX_LAST) ? '0 : chip_idx + 5'd1;
                lfsr     <= {lfsr[0] ^ lfsr[2], lfsr[4:1]};
            end

            if (bit_edge) begin
                cur_bit <= buf_full & buf_bit;
                if (!buf_full) begin
                    underrun <= 1'b1;
                end
            end

            // An accept only happens with the buffer empty, so when it lands
            // on a boundary the unload has nothing to take and the new bit
            // simply waits for the following boundary.
            if (accept) begin
                buf_full <= 1'b1;
                buf_bit  <= din;
            end else if (bit_edge) begin
                buf_full <= 1'b0;
            end
        end
    end

    // Fold the 8-bit phase index onto the quarter table; the sample sign is
    // the half-wave sign combined with the chip value.
    always_comb begin
        q_idx = s1_k[6] ? (7'd64 - {1'b0, s1_k[5:0]}) : {1'b0, s1_k[5:0]};
        mag   = quarter_sine(q_idx);
        neg   = s1_k[7] ^ s1_s;
        mag_s = $signed({1'b0, mag});
    end

    // Two-stage output pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_k     <= '0;
            s1_s     <= 1'b0;
            s1_b     <= 1'b0;
            dout     <= '0;
            pn       <= 1'b0;
            bit_sync <= 1'b0;
        end else begin
            s1_k     <= phase_acc[31:24];
            s1_s     <= cur_bit ^ lfsr[0];
            s1_b     <= (chip_cnt == '0) && (chip_idx == '0);
            dout     <= neg ? -mag_s : mag_s;
            pn       <= s1_s;
            bit_sync <= s1_b;
        end
    end

endmodule

// File: tb/tb_dsss_mod.sv
module tb_dsss_mod;

    localparam int unsigned CD   = 16;
    localparam int unsigned P    = 31 * CD;
    localparam logic [31:0] FW_A = 32'h4000_0000;
    localparam logic [31:0] FW_B = 32'd692736661;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic din_valid = 1'b0;

    logic              ready_a, ready_b;
    logic signed [7:0] dout_a, dout_b;
    logic              bs_a, bs_b, pn_a, pn_b, ur_a, ur_b;

    dsss_mod #(.CHIP_DIV(CD), .FREQ_WORD(FW_A)) dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(ready_a), .dout(dout_a), .bit_sync(bs_a), .pn(pn_a),
        .underrun(ur_a)
    );

    dsss_mod #(.CHIP_DIV(CD), .FREQ_WORD(FW_B)) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(ready_b), .dout(dout_b), .bit_sync(bs_b), .pn(pn_b),
        .underrun(ur_b)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passed = 0;

    // Reference model state
    logic [30:0] pn_seq;
    logic        bit_val [0:127];
    logic        m_full, m_buf, m_und;
    int unsigned n;
    logic        live = 1'b0;
    int          scen = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s (scenario %0d, cycle %0d): got %0d, expected %0d",
                      name, scen, n, act, exp);
    endtask

    function automatic int sine_ref(input int k);
        real r;
        r = 127.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 256.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    function automatic logic pn_chip(input int unsigned c);
        return pn_seq[30 - c];
    endfunction

    task automatic model_reset();
        n         = 0;
        m_full    = 1'b0;
        m_buf     = 1'b0;
        m_und     = 1'b0;
        bit_val[0] = 1'b0;
        live      = 1'b1;
    endtask

    task automatic model_step(input logic v, input logic d);
        logic acc;
        acc = v && !m_full;
        if (n % P == P - 1) begin
            bit_val[n / P + 1] = m_full ? m_buf : 1'b0;
            if (!m_full) m_und = 1'b1;
            m_full = 1'b0;
        end
        if (acc) begin
            m_full = 1'b1;
            m_buf  = d;
        end
        n++;
    endtask

    task automatic check_outputs();
        int          exp_da, exp_db;
        logic        exp_pn, exp_bs, s;
        logic [63:0] ph_a, ph_b;
        int unsigned n0;
        int          lit_d [4];
        lit_d = '{0, -127, 0, 127};
        if (n < 2) begin
            exp_da = 0; exp_db = 0; exp_pn = 1'b0; exp_bs = 1'b0;
        end else begin
            n0     = n - 2;
            s      = bit_val[n0 / P] ^ pn_chip((n0 / CD) % 31);
            ph_a   = 64'(n0) * 64'(FW_A);
            ph_b   = 64'(n0) * 64'(FW_B);
            exp_da = sine_ref(int'(ph_a[31:24]));
            exp_db = sine_ref(int'(ph_b[31:24]));
            if (s) begin
                exp_da = -exp_da;
                exp_db = -exp_db;
            end
            exp_pn = s;
            exp_bs = (n0 % P == 0);
        end
        chk("dout_a", int'(dout_a), exp_da);
        chk("dout_b", int'(dout_b), exp_db);
        chk("pn_a", int'(pn_a), int'(exp_pn));
        chk("pn_b", int'(pn_b), int'(exp_pn));
        chk("bit_sync_a", int'(bs_a), int'(exp_bs));
        chk("bit_sync_b", int'(bs_b), int'(exp_bs));
        chk("underrun_a", int'(ur_a), int'(m_und));
        chk("underrun_b", int'(ur_b), int'(m_und));
        chk("dout_b_no_min", int'(dout_b == -8'sd128), 0);

        // Hand-computed expectations that pin the model itself
        if (scen == 1) begin
            if (n >= 2 && n <= 5) chk("lit_dout_first", int'(dout_a), lit_d[n - 2]);
            if (n == 2)   chk("lit_bit_sync_first", int'(bs_a), 1);
            if (n == 81)  chk("lit_pn_chip4", int'(pn_a), 1);
            if (n == 82)  chk("lit_pn_chip5", int'(pn_a), 0);
            if (n == 129) chk("lit_pn_chip7", int'(pn_a), 0);
            if (n == 495) chk("lit_underrun_before", int'(ur_a), 0);
            if (n == 496) chk("lit_underrun_after", int'(ur_a), 1);
            if (n == P + 2) chk("lit_bit_sync_second", int'(bs_a), 1);
        end
        if (scen == 2) begin
            if (n == P + 2)     chk("lit_pn_bit1_inverted", int'(pn_a), 0);
            if (n == 2 * P + 2) chk("lit_pn_bit2_normal", int'(pn_a), 1);
            if (n == 3 * P + 2) chk("lit_pn_bit3_inverted", int'(pn_a), 0);
            if (n == 4 * P - 1) chk("lit_underrun_hold", int'(ur_a), 0);
            if (n == 4 * P)     chk("lit_underrun_set", int'(ur_a), 1);
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic d, output logic acc);
        @(negedge clk);
        if (live) check_outputs();
        rst       = r;
        din_valid = v;
        din       = d;
        #1;
        chk("din_ready_a", int'(ready_a), int'(!r && !m_full));
        chk("din_ready_b", int'(ready_b), int'(!r && !m_full));
        if (scen == 1 && n == 0 && !r) chk("lit_ready_after_reset", int'(ready_a), 1);
        if (scen == 2 && !r) begin
            if (n == 1)     chk("lit_ready_full", int'(ready_a), 0);
            if (n == P)     chk("lit_ready_after_unload", int'(ready_a), 1);
            if (n == 5 * P) chk("lit_ready_edge_accept", int'(ready_a), 0);
        end
        acc = !r && v && !m_full;
        if (r) model_reset();
        else model_step(v, d);
    endtask

    initial begin
        logic        acc, v, d;
        int unsigned idx;
        int unsigned permille;
        logic [2:0]  pat;

        pn_seq = 31'b1111100011011101010000100101100;
        m_full = 1'b0;
        m_buf  = 1'b0;
        m_und  = 1'b0;
        n      = 0;

        // Reset and first bits with no data offered
        scen = 1;
        repeat (3) cycle(1'b1, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3 * P; i++) cycle(1'b0, 1'b0, 1'b0, acc);

        // Bits 1,0,1 with valid held, then an accept landing on a boundary
        scen = 0;
        cycle(1'b1, 1'b0, 1'b0, acc);
        scen = 2;
        pat  = 3'b101;
        idx  = 0;
        for (int i = 0; i < 7 * P + 10; i++) begin
            if (n == 5 * P - 1) begin
                v = 1'b1; d = 1'b1;
            end else begin
                v = (idx < 3);
                d = (idx < 3) ? pat[2 - idx] : 1'b0;
            end
            cycle(1'b0, v, d, acc);
            if (acc && idx < 3) idx++;
        end

        // Random handshake at several offered-load levels
        scen = 0;
        cycle(1'b1, 1'b0, 1'b0, acc);
        scen = 3;
        for (int i = 0; i < 40 * P; i++) begin
            permille = (n / P < 12) ? 500 : ((n / P < 26) ? 4 : 1);
            v = ($urandom_range(0, 999) < permille);
            d = 1'($urandom_range(0, 1));
            cycle(1'b0, v, d, acc);
        end

        // Reset mid-bit at chip index 17 with the buffer full
        scen = 0;
        cycle(1'b1, 1'b0, 1'b0, acc);
        scen = 4;
        cycle(1'b0, 1'b1, 1'b1, acc);
        while (n < 17 * CD + 5) cycle(1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 1'b0, 1'b0, acc);
        scen = 1;
        for (int i = 0; i < 2 * P; i++) cycle(1'b0, 1'b0, 1'b0, acc);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
